// File: rtl/cpu_traffic_gen.sv
// cpu_traffic_gen: CPU-side bus traffic generator for exercising a memory
// controller. A run writes a deterministic address-derived pattern over a
// configurable window and reads it back, counting data mismatches.
//
// Ports
//   sysclk, reset_n       clock (rising edge) and async active-low reset
//   start                 one-cycle pulse launching a run (ignored while busy)
//   cfg_base/count/mode/throttle
//                         run configuration, sampled on start
//   cpuAddr, cpuState, cpuL, cpuU, cpuLongWord, cpuWR
//                         request side towards the controller
//   cpuRD, cpuena         read data and access-complete strobe
//   busy, done, err       run status (done/err sticky until next start)
//   err_cnt, err_addr     saturating mismatch count, first mismatch address
//
// cpuAddr carries word address bits [24:1] in its [23:0] range.
module cpu_traffic_gen #(
    parameter int          STRIDE  = 1,
    parameter int          CNT_W   = 16,
    parameter logic [15:0] SEED    = 16'hA55A,
    parameter int          TIMEOUT = 1024
) (
    input  logic             sysclk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [23:0]      cfg_base,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [1:0]       cfg_mode,
    input  logic [3:0]       cfg_throttle,
    output logic [23:0]      cpuAddr,
    output logic [1:0]       cpuState,
    output logic             cpuL,
    output logic             cpuU,
    output logic             cpuLongWord,
    output logic [15:0]      cpuWR,
    input  logic [15:0]      cpuRD,
    input  logic             cpuena,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [23:0]      err_addr
);

    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [1:0] MODE_WR_RD = 2'b00;
    localparam logic [1:0] MODE_WR    = 2'b01;
    localparam logic [1:0] MODE_RD    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WGAP, S_RD, S_RGAP, S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [23:0]      addr_q, base_q;
    logic [CNT_W-1:0] cnt_q, acc_cnt;
    logic [1:0]       mode_q;
    logic [3:0]       thr_q, gap_cnt;
    logic [WD_W-1:0]  wd_cnt;

    logic in_access, complete, timeout, launch, last, gap_done, wd_expired;

    function automatic logic [15:0] pat(input logic [23:0] a);
        return {a[7:0], ~a[7:0]} ^ SEED;
    endfunction

    assign cpuAddr     = addr_q;
    assign cpuLongWord = 1'b0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        in_access  = 1'b0;
        complete   = 1'b0;
        timeout    = 1'b0;
        launch     = 1'b0;
        last       = (acc_cnt == cnt_q - 1'b1);
        gap_done   = (gap_cnt == thr_q);
        wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));

        case (state_q)
            S_IDLE, S_FIN: begin
                if (start) begin
                    launch = 1'b1;
                    if (cfg_count == '0)         state_d = S_FIN;
                    else if (cfg_mode == MODE_RD) state_d = S_RD;
                    else                          state_d = S_WR;
                end
            end
            S_WR, S_RD: begin
                in_access = 1'b1;
                if (cpuena) begin
                    complete = 1'b1;
                    // The final access of a phase moves straight on; throttle
                    // gaps only separate accesses within a phase.
                    if (last) begin
                        if (state_q == S_WR && mode_q != MODE_WR) state_d = S_RD;
                        else                                       state_d = S_FIN;
                    end else if (thr_q != 4'd0) begin
                        state_d = (state_q == S_WR) ? S_WGAP : S_RGAP;
                    end
                end else if (wd_expired) begin
                    timeout = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_WGAP:  if (gap_done) state_d = S_WR;
            S_RGAP:  if (gap_done) state_d = S_RD;
            default: state_d = S_IDLE;
        endcase

        cpuState = 2'b01;
        if (state_q == S_WR)      cpuState = 2'b11;
        else if (state_q == S_RD) cpuState = 2'b10;
        cpuL  = ~in_access;
        cpuU  = ~in_access;
        cpuWR = (state_q == S_WR) ? pat(addr_q) : 16'h0000;
        busy  = (state_q != S_IDLE) && (state_q != S_FIN);
        done  = (state_q == S_FIN);
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q   <= '0;
            base_q   <= '0;
            cnt_q    <= '0;
            acc_cnt  <= '0;
            mode_q   <= MODE_WR_RD;
            thr_q    <= '0;
            gap_cnt  <= '0;
            wd_cnt   <= '0;
            err      <= 1'b0;
            err_cnt  <= '0;
            err_addr <= '0;
        end else if (launch) begin
            addr_q   <= cfg_base;
            base_q   <= cfg_base;
            cnt_q    <= cfg_count;
            acc_cnt  <= '0;
            mode_q   <= (cfg_mode == 2'b11) ? MODE_WR_RD : cfg_mode;
            thr_q    <= cfg_throttle;
            wd_cnt   <= '0;
            err      <= 1'b0;
            err_cnt  <= '0;
            err_addr <= '0;
        end else begin
            if (complete) begin
                wd_cnt  <= '0;
                gap_cnt <= 4'd1;   // completion-edge counts as first gap cycle
                if (last) begin
                    acc_cnt <= '0;
                    // Write phase of a write-then-read run rewinds for readback.
                    if (state_q == S_WR && mode_q != MODE_WR) addr_q <= base_q;
                    else                                       addr_q <= addr_q + 24'(STRIDE);
                end else begin
                    acc_cnt <= acc_cnt + 1'b1;
                    addr_q  <= addr_q + 24'(STRIDE);
                end
                if (state_q == S_RD && cpuRD != pat(addr_q)) begin
                    err <= 1'b1;
                    if (err_cnt == '0) err_addr <= addr_q;
                    if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                end
            end else if (in_access) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else if (state_q == S_WGAP || state_q == S_RGAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
            if (timeout) err <= 1'b1;
        end
    end

endmodule

// File: doc/cpu_traffic_gen.md
CPU_TRAFFIC_GEN -- requirements
Module: cpu_traffic_gen

Interface
REQ-001 SHALL have parameter STRIDE, default 1, meaning word-address increment per access (1..255).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of access count and error counter.
REQ-003 SHALL have parameter SEED, default 16'hA55A, meaning XOR key for data pattern.
REQ-004 SHALL have parameter TIMEOUT, default 1024, meaning max cycles waiting for cpuena per access.
REQ-005 SHALL have port sysclk  in  1  system clock; all state on rising edge.
REQ-006 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  in  1  one-cycle pulse launching a run.
REQ-008 SHALL have port cfg_base  in  24  start word address [24:1].
REQ-009 SHALL have port cfg_count  in  CNT_W  accesses per phase.
REQ-010 SHALL have port cfg_mode  in  2  00 write-then-read, 01 write-only, 10 read-only, 11 reserved (treated as 00).
REQ-011 SHALL have port cfg_throttle  in  4  idle cycles inserted after each access.
REQ-012 SHALL have port cpuAddr  out  24  word address [24:1].
REQ-013 SHALL have port cpuState  out  2  01 idle, 10 data read, 11 write.
REQ-014 SHALL have port cpuL, cpuU  out  1 each  byte enables, active-low.
REQ-015 SHALL have port cpuLongWord  out  1  tied 0.
REQ-016 SHALL have port cpuWR  out  16  write data.
REQ-017 SHALL have port cpuRD  in  16  read data from controller.
REQ-018 SHALL have port cpuena  in  1  access-complete strobe from controller.
REQ-019 SHALL have port busy, done, err  out  1 each  run active, run finished (sticky until start), any error (sticky until start).
REQ-020 SHALL have port err_cnt  out  CNT_W  mismatch count, saturating.
REQ-021 SHALL have port err_addr  out  24  address of first mismatch.

Function
REQ-022 SHALL implement states IDLE, WR, WGAP, RD, RGAP, FIN.
REQ-023 start in IDLE or FIN SHALL load cfg_*, clear done/err/err_cnt/err_addr, set busy, go to WR (mode 00/01) or RD (mode 10) next cycle.
REQ-024 start while busy SHALL be ignored.
REQ-025 cfg_count=0 SHALL go directly IDLE->FIN, done=1 next cycle, no bus access.
REQ-026 In WR/RD, cpuAddr, cpuState, cpuWR, cpuL=cpuU=0 SHALL stay stable until the cycle cpuena=1; that cycle completes the access.
REQ-027 Pattern SHALL be pat(a) = {a[8:1], ~a[8:1]} ^ SEED, computed from the access word address.
REQ-028 Write data cpuWR SHALL equal pat(cpuAddr).
REQ-029 On read completion, cpuRD != pat(cpuAddr) SHALL increment err_cnt (saturate at all-ones), set err, and capture err_addr only on the first mismatch.
REQ-030 After each completion, address SHALL advance by STRIDE modulo 2^24 (wrap 24'hFFFFFF->24'h000000 for STRIDE=1).
REQ-031 WGAP/RGAP SHALL drive cpuState=01, cpuL=cpuU=1 for exactly cfg_throttle cycles; throttle 0 SHALL issue the next access on the cycle after completion.
REQ-032 After cfg_count writes: mode 00 SHALL reload address to cfg_base and enter RD; mode 01 SHALL enter FIN.
REQ-033 After cfg_count reads SHALL enter FIN.
REQ-034 FIN SHALL set done=1, busy=0, cpuState=01, and hold until start.
REQ-035 A per-access watchdog SHALL count cycles in WR/RD; reaching TIMEOUT without cpuena SHALL set err, go to FIN; err_cnt unchanged.
REQ-036 Outside WR/RD, cpuState SHALL be 01 and cpuL=cpuU=1.

Reset
REQ-037 reset_n=0 SHALL asynchronously force IDLE, cpuState=01, cpuAddr=0, cpuWR=0, cpuL=cpuU=1, busy=done=err=0, err_cnt=0, err_addr=0, even mid-access.
REQ-038 After reset_n release, no access SHALL start without a new start pulse.

Verification
REQ-039 base=0x000100, count=4, mode 00, throttle 0, ideal model -> 4 writes then 4 reads at 0x100..0x103, err_cnt=0, done=1.
REQ-040 Same run, model corrupts read at 0x102 and 0x103 -> err=1, err_cnt=2, err_addr=0x000102.
REQ-041 base=0xFFFFFE, count=3, mode 01, STRIDE=1 -> addresses 0xFFFFFE, 0xFFFFFF, 0x000000.
REQ-042 throttle=3, controller asserts cpuena 2 cycles after request -> exactly 3 idle (cpuState=01) cycles between accesses.
REQ-043 cpuena never asserted, TIMEOUT=16 -> err=1, done=1 after 16 cycles in WR, err_cnt=0.
REQ-044 reset_n low during RD of a run -> all outputs at reset values immediately; start afterwards runs normally.
